out_act_read_arbiter: RTL
=========================

// Module: out_act_read_arbiter
// PURPOSE
// - Sequential arbiter for the single output-activation regfile read port. Sharers: ADD pipeline stage
//   (read-modify-write accumulate) and network-interface (NI) result readout.
// - Adds WB->ADD / WB->NI forwarding, NI request buffering, a starvation guard that stalls the PE
//   controller, and a registered NI read response.
// - Sits between ADD, the activation regfile, the NI and the PE controller.
// PARAMETERS
// - ACT_ADDR_W    6   output activation address width (matches PE act-no bus)
// - DATA_W       16   activation data width (matches PE data bus)
// - STARVE_LIMIT  8   consecutive blocked NI cycles before comp_stall is raised (>=1)
// PORTS
// - clk                 in   1             system clock; single clock domain
// - rst                 in   1             synchronous reset, active high
// - comp_en_add         in   1             ADD stage valid; needs read port this cycle
// - out_act_addr_add    in   ACT_ADDR_W    ADD read address
// - out_act_value_add   out  DATA_W        operand to ADD (forwarded or regfile data)
// - comp_en_wb          in   1             WB write enable to regfile
// - out_act_addr_wb     in   ACT_ADDR_W    WB write address
// - add_result_wb       in   DATA_W        WB write data
// - out_act_clear       in   1             regfile clear in progress; NI grants blocked
// - ni_read_rqst        in   1             1-cycle request pulse from NI
// - ni_read_addr        in   ACT_ADDR_W    NI read address, valid with rqst pulse
// - ni_read_valid       out  1             1-cycle response strobe
// - ni_read_data        out  DATA_W        response data, valid with ni_read_valid
// - comp_stall          out  1             PE controller must hold comp_en low while high
// - out_act_read_en     out  1             regfile read enable
// - out_act_read_addr   out  ACT_ADDR_W    regfile read address
// - out_act_read_data   in   DATA_W        regfile read data; combinational, same cycle
// BEHAVIOUR
// - Reset: state=IDLE, pend_addr=0, starve_cnt=0, ni_read_valid=0, ni_read_data=0, comp_stall=0.
//   Reset mid-transaction drops the pending NI request with no response.
// - Priority: ADD always wins the read port. NI is granted only when:
//   !comp_en_add && !out_act_clear && (IDLE with rqst || WAIT).
// - Read port:
//   - comp_en_add=1: read_en=1, read_addr=out_act_addr_add.
//   - NI grant: read_en=1, read_addr = IDLE ? ni_read_addr : pend_addr.
//   - otherwise: read_en=0, read_addr=0.
// - Forwarding: if comp_en_wb && out_act_addr_wb == granted read_addr, the consumer gets
//   add_result_wb; otherwise it gets out_act_read_data. Applies to both ADD and NI.
//   out_act_value_add is combinational and is don't-care when comp_en_add=0.
// - FSM:
//   - IDLE: rqst && grant -> RESP. rqst && blocked -> latch pend_addr, starve_cnt=1 -> WAIT.
//   - WAIT: grant -> RESP. Else starve_cnt++ (saturates at STARVE_LIMIT).
//   - RESP: ni_read_valid=1 for exactly this cycle -> IDLE.
// - NI read latency: granted in cycle t -> ni_read_data registered, ni_read_valid=1 in t+1.
//   Minimum 1 cycle; unbounded while blocked.
// - NI protocol: at most one outstanding request. A rqst pulse in WAIT or RESP is ignored,
//   with no response.
// - Starvation:
//   - comp_stall <= 1 on the clock where starve_cnt reaches STARVE_LIMIT in WAIT.
//   - It stays 1 until the grant cycle and is 0 from the RESP cycle on.
//   - In-flight MEM/MULT/ADD ops (<=3 cycles) still drain with priority. The grant follows the first
//     ADD-idle cycle.
// - Simultaneous ADD + NI rqst: ADD served; NI moves to WAIT.
// - Clear overlapping WAIT: NI waits for clear to end. starve_cnt counts clear cycles too.
// STRUCTURE
// - Shared package pe_arb_pkg: state enum {IDLE, WAIT, RESP} (2-bit), default STARVE_LIMIT,
//   widths tied to the PE act-no and data bus defines.
// - One natural sub-module: act_fwd_mux. Combinational address compare plus 2:1 select, instantiated
//   twice (ADD path, NI path).
// - Top level holds the FSM, pend_addr, starve_cnt, the response registers and comp_stall.
// TESTING
// - NI rqst addr=5 while comp_en_add=0, regfile[5]=0x0123 -> read_addr=5 same cycle;
//   ni_read_valid=1, data=0x0123 next cycle.
// - NI rqst addr=3 with comp_en_add=1 (addr=9) for 2 cycles -> port serves 9, then 3; valid 1 cycle
//   after grant, 3 cycles after rqst.
// - comp_en_add held high 10 cycles, STARVE_LIMIT=8, NI pending:
//   - comp_stall rises after 8 WAIT cycles.
//   - grant on first cycle comp_en_add=0; comp_stall=0 in RESP.
// - comp_en_add addr=7 with comp_en_wb addr=7 data=0x00AA, regfile[7]=0x0011
//   -> out_act_value_add=0x00AA. Repeat with wb addr=6 -> 0x0011.
// - NI rqst during out_act_clear=1 for 4 cycles -> no grant during clear; grant on first
//   clear=0 cycle; response data reflects post-clear value (0).
// - rst asserted in WAIT and in RESP -> next cycle valid=0, stall=0, state IDLE; a second rqst in WAIT
//   is ignored and yields exactly one response.

Source files
------------

// File: rtl/pe_arb_pkg.sv
// Shared definitions for the output-activation read-port arbiter: bus widths
// tied to the PE act-no and data buses, the default starvation limit and the
// NI request state encoding.
package pe_arb_pkg;

  localparam int PE_ACT_NO_W      = 6;
  localparam int PE_DATA_W        = 16;
  localparam int DEF_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/act_fwd_mux.sv
// Write-back forwarding select: a consumer reading the address that WB is
// writing this cycle gets the fresh WB data instead of the stale regfile data.
module act_fwd_mux
  import pe_arb_pkg::*;
#(
  parameter int ADDR_W = PE_ACT_NO_W,
  parameter int DATA_W = PE_DATA_W
) (
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] sel_data
);

  assign sel_data = (wb_en && (wb_addr == rd_addr)) ? wb_data : rd_data;

endmodule

// File: rtl/out_act_read_arbiter.sv
// Arbiter for the single read port of the output-activation regfile.
// ADD always wins; NI reads are buffered in WAIT until the port is free and
// clear is not running, with a starvation guard that stalls the PE controller.
module out_act_read_arbiter
  import pe_arb_pkg::*;
#(
  parameter int ACT_ADDR_W   = PE_ACT_NO_W,
  parameter int DATA_W       = PE_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  comp_en_add,
  input  logic [ACT_ADDR_W-1:0] out_act_addr_add,
  output logic [DATA_W-1:0]     out_act_value_add,
  input  logic                  comp_en_wb,
  input  logic [ACT_ADDR_W-1:0] out_act_addr_wb,
  input  logic [DATA_W-1:0]     add_result_wb,
  input  logic                  out_act_clear,
  input  logic                  ni_read_rqst,
  input  logic [ACT_ADDR_W-1:0] ni_read_addr,
  output logic                  ni_read_valid,
  output logic [DATA_W-1:0]     ni_read_data,
  output logic                  comp_stall,
  output logic                  out_act_read_en,
  output logic [ACT_ADDR_W-1:0] out_act_read_addr,
  input  logic [DATA_W-1:0]     out_act_read_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  arb_state_t            state;
  logic [ACT_ADDR_W-1:0] pend_addr;
  logic [CNT_W-1:0]      starve_cnt;

  logic                  ni_active;
  logic                  ni_grant;
  logic [ACT_ADDR_W-1:0] ni_addr;
  logic [DATA_W-1:0]     ni_value;

  // A live NI request is either a fresh pulse in IDLE or the buffered one in WAIT.
  assign ni_active = ((state == IDLE) && ni_read_rqst) || (state == WAIT);
  assign ni_grant  = ni_active && !comp_en_add && !out_act_clear;
  assign ni_addr   = (state == IDLE) ? ni_read_addr : pend_addr;

  // Read-port steering: ADD first, then a granted NI read, otherwise parked at 0.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    out_act_read_en   = 1'b0;
    out_act_read_addr = '0;
    if (comp_en_add) begin
      out_act_read_en   = 1'b1;
      out_act_read_addr = out_act_addr_add;
    end else if (ni_grant) begin
      out_act_read_en   = 1'b1;
      out_act_read_addr = ni_addr;
    end
  end

  act_fwd_mux #(.ADDR_W(ACT_ADDR_W), .DATA_W(DATA_W)) u_fwd_add (
    .wb_en    (comp_en_wb),
    .wb_addr  (out_act_addr_wb),
    .wb_data  (add_result_wb),
    .rd_addr  (out_act_addr_add),
    .rd_data  (out_act_read_data),
    .sel_data (out_act_value_add)
  );

  act_fwd_mux #(.ADDR_W(ACT_ADDR_W), .DATA_W(DATA_W)) u_fwd_ni (
    .wb_en    (comp_en_wb),
    .wb_addr  (out_act_addr_wb),
    .wb_data  (add_result_wb),
    .rd_addr  (ni_addr),
    .rd_data  (out_act_read_data),
    .sel_data (ni_value)
  );

  // NI request FSM with starvation counter, registered response and stall flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only control/state registers need reset; every one here is small, so all are reset.
      state         <= IDLE;
      pend_addr     <= '0;
      starve_cnt    <= '0;
      ni_read_valid <= 1'b0;
      ni_read_data  <= '0;
      comp_stall    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ni_read_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ni_read_rqst) begin
            if (ni_grant) begin
              state         <= RESP;
              ni_read_valid <= 1'b1;
              ni_read_data  <= ni_value;
            end else begin
              state      <= WAIT;
              pend_addr  <= ni_read_addr;
              starve_cnt <= CNT_ONE;
              comp_stall <= (CNT_ONE >= CNT_LIMIT);
            end
          end
        end
        WAIT: begin
          if (ni_grant) begin
            state         <= RESP;
            ni_read_valid <= 1'b1;
            ni_read_data  <= ni_value;
            starve_cnt    <= '0;
            comp_stall    <= 1'b0;
          end else if (starve_cnt < CNT_LIMIT) begin
            starve_cnt <= starve_cnt + CNT_ONE;
            if ((starve_cnt + CNT_ONE) >= CNT_LIMIT) comp_stall <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
